// File: rtl/dmac_rd_ch_sched.sv
// -----------------------------------------------------------------------------
// dmac_rd_ch_sched
//   Read-channel command scheduler for the DMA controller. Up to CHANNEL_COUNT
//   channels post read commands; one is picked round-robin, its descriptor is
//   registered onto the cmd_* bus and offered to the read datapath. Commands
//   in flight are tracked per channel (ch_busy) and in total (outstanding),
//   and are retired by done_valid/done_ch_id.
//
// Ports
//   clk, rst_n                  single rising-edge clock, async active-low reset
//   ch_req_valid/ch_req_ready   per-channel request / same-cycle accept pulse
//   ch_src_addr, ch_dst_addr,
//   ch_len, ch_burst, ch_size   per-channel descriptor fields, packed by index
//   cmd_valid/cmd_ready         command handshake to the read datapath
//   cmd_*                       registered descriptor of the selected channel
//   cmd_ch_id                   channel owning the current command
//   done_valid/done_ch_id       completion of one issued command
//   ch_busy                     channel has a command in flight
//   ch_done                     one-cycle completion pulse per channel
//   outstanding                 number of commands in flight
//   err_spurious_done           sticky: done for a non-busy or invalid channel
// -----------------------------------------------------------------------------
module dmac_rd_ch_sched #(
    parameter int ADDR_WD         = 32,
    parameter int CHANNEL_COUNT   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic [CHANNEL_COUNT-1:0]              ch_req_valid,
    output logic [CHANNEL_COUNT-1:0]              ch_req_ready,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]      ch_src_addr,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]      ch_dst_addr,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]      ch_len,
    input  logic [CHANNEL_COUNT*2-1:0]            ch_burst,
    input  logic [CHANNEL_COUNT*3-1:0]            ch_size,

    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [ADDR_WD-1:0]                    cmd_src_addr,
    output logic [ADDR_WD-1:0]                    cmd_dst_addr,
    output logic [ADDR_WD-1:0]                    cmd_len,
    output logic [1:0]                            cmd_burst,
    output logic [2:0]                            cmd_size,
    output logic [$clog2(CHANNEL_COUNT)-1:0]      cmd_ch_id,

    input  logic                                  done_valid,
    input  logic [$clog2(CHANNEL_COUNT)-1:0]      done_ch_id,

    output logic [CHANNEL_COUNT-1:0]              ch_busy,
    output logic [CHANNEL_COUNT-1:0]              ch_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
    output logic                                  err_spurious_done
);

    localparam int CH_W  = $clog2(CHANNEL_COUNT);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNEL_COUNT);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_COUNT - 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                 state, state_nxt;
    logic [CH_W-1:0]        rr_ptr;

    logic [CHANNEL_COUNT-1:0] eligible;
    logic                   sel_found;
    logic [CH_W-1:0]        sel_idx;
    logic [CH_W:0]          cand_w;
    logic                   sel_fire;
    logic                   sel_zero_len;
    logic                   cmd_hs;
    logic                   done_in_range;
    logic                   done_ok;
    logic [CHANNEL_COUNT-1:0] busy_nxt;
    logic [CHANNEL_COUNT-1:0] done_nxt;

    assign eligible = ch_req_valid & ~ch_busy;

    // Round-robin search: first eligible channel at or above rr_ptr, wrapping.
    // The sum is carried one bit wider so the wrap is a single subtract.
    // NOTE: every variable assigned in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_w    = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            cand_w = {1'b0, rr_ptr} + (CH_W + 1)'(k);
            if (cand_w >= CH_LIMIT) begin
                cand_w = cand_w - CH_LIMIT;
            end
            if (!sel_found && eligible[cand_w[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand_w[CH_W-1:0];
            end
        end
    end

    // Gating with rst_n keeps ch_req_ready low while reset is held, so no
    // request is acknowledged that the scheduler would then forget.
    assign sel_fire     = rst_n && (state == IDLE) && (outstanding < OUT_MAX) && sel_found;
    assign sel_zero_len = (ch_len[sel_idx*ADDR_WD +: ADDR_WD] == '0);

    always_comb begin
        ch_req_ready = '0;
        if (sel_fire) begin
            ch_req_ready[sel_idx] = 1'b1;
        end
    end

    // FSM next state and cmd_valid
    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        case (state)
            IDLE: begin
                if (sel_fire && !sel_zero_len) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_hs = (state == ISSUE) && cmd_ready;

    // A done is honoured only for an in-range, busy channel; anything else is
    // flagged and otherwise ignored, which also stops outstanding underflowing.
    assign done_in_range = ({1'b0, done_ch_id} < CH_LIMIT);
    assign done_ok       = done_valid && done_in_range && ch_busy[done_ch_id];

    // Clear first, then set: a done and a handshake on the same channel in one
    // cycle leave the channel busy.
    always_comb begin
        busy_nxt = ch_busy;
        if (done_ok) begin
            busy_nxt[done_ch_id] = 1'b0;
        end
        if (cmd_hs) begin
            busy_nxt[cmd_ch_id] = 1'b1;
        end
    end

    // Completion pulses: one from a real done, one from a zero-length accept.
    always_comb begin
        done_nxt = '0;
        if (done_ok) begin
            done_nxt[done_ch_id] = 1'b1;
        end
        if (sel_fire && sel_zero_len) begin
            done_nxt[sel_idx] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            outstanding       <= '0;
            ch_busy           <= '0;
            ch_done           <= '0;
            cmd_src_addr      <= '0;
            cmd_dst_addr      <= '0;
            cmd_len           <= '0;
            cmd_burst         <= '0;
            cmd_size          <= '0;
            cmd_ch_id         <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch_busy <= busy_nxt;
            ch_done <= done_nxt;

            if (sel_fire) begin
                rr_ptr       <= (sel_idx == CH_LAST) ? '0 : sel_idx + 1'b1;
                cmd_src_addr <= ch_src_addr[sel_idx*ADDR_WD +: ADDR_WD];
                cmd_dst_addr <= ch_dst_addr[sel_idx*ADDR_WD +: ADDR_WD];
                cmd_len      <= ch_len[sel_idx*ADDR_WD +: ADDR_WD];
                cmd_burst    <= ch_burst[sel_idx*2 +: 2];
                cmd_size     <= ch_size[sel_idx*3 +: 3];
                cmd_ch_id    <= sel_idx;
            end

            // Handshake only happens below OUT_MAX and done_ok implies a busy
            // channel, so neither direction can wrap.
            case ({cmd_hs, done_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (done_valid && !done_ok) begin
                err_spurious_done <= 1'b1;
            end
        end
    end

endmodule
